logic_issue: RTL
================

LOGIC_ISSUE -- requirements
Module: logic_issue

Interface
REQ-001 Parameter: W, 4, operand/result width in bits.
REQ-002 Parameter: NREG, 4, register-file depth; address width is clog2(NREG) (2 at default).
REQ-003 Port: clk input 1, single clock; all state updates on its rising edge.
REQ-004 Port: rst_n input 1, reset, asynchronous, active-low.
REQ-005 Port: cmd_valid input 1, command offered.
REQ-006 Port: cmd_ready output 1, block can accept a command.
REQ-007 Port: cmd_op input 4, logic-unit select code.
REQ-008 Port: cmd_rd, cmd_rs1, cmd_rs2 input 2 each, destination and source register addresses.
REQ-009 Port: cmd_imm_en input 1, selects cmd_imm instead of reg[rs2] as second operand; cmd_imm input W.
REQ-010 Port: ld_en input 1, ld_addr input 2, ld_data input W, direct register-file write port.
REQ-011 Port: alu_in1, alu_in2 output W, alu_sel output 4, drive the downstream logic unit.
REQ-012 Port: alu_out input W, combinational result returned from the logic unit.
REQ-013 Port: res_valid output 1, res_err output 1, res_data output W, res_rd output 2, result report.

Function
REQ-014 The FSM SHALL have states IDLE, EXEC, WB; cmd_ready SHALL be 1 only in IDLE.
REQ-015 A command SHALL be accepted on a rising edge with cmd_valid=1 and cmd_ready=1 (edge E0); it captures op, rd, operand1=reg[rs1], operand2=(cmd_imm_en ? cmd_imm : reg[rs2]), and the FSM moves to EXEC.
REQ-016 If ld_en targets rs1 or rs2 on E0, the captured operand SHALL be ld_data (bypass).
REQ-017 In EXEC, alu_in1/alu_in2/alu_sel SHALL hold the captured values; they SHALL remain stable until the next acceptance.
REQ-018 On the edge leaving EXEC (E1), alu_out SHALL be registered into res_data, and rd into res_rd; the FSM moves to WB.
REQ-019 In WB, res_valid SHALL be 1 for exactly one cycle; the FSM returns to IDLE on E2; accept-to-res_valid latency is 2 cycles; peak throughput is one command per 3 cycles.
REQ-020 Valid op codes SHALL be 4'b0000-4'b1001; for a valid op, reg[rd] SHALL be written with res_data on E2 and res_err SHALL be 0.
REQ-021 For op >= 4'b1010, res_err SHALL be 1 with res_valid, res_data SHALL be 0, and no register write SHALL occur.
REQ-022 ld_en SHALL write reg[ld_addr] in any state; if it collides with the WB write to the same address on E2, the WB write SHALL win.
REQ-023 cmd_valid in EXEC/WB SHALL be ignored (no capture); the upstream holds it until cmd_ready.
REQ-024 res_data, res_rd and res_err SHALL hold their last values outside WB.

Reset
REQ-025 While rst_n=0: state=IDLE, all registers=0, captured operands=0, alu_*=0, res_*=0, and cmd_ready=0; cmd_ready SHALL be 1 from the first cycle after release.
REQ-026 Reset asserted in EXEC or WB SHALL abort the command with no res_valid and no register write.

Structure
REQ-027 The shared package logic_pkg SHALL hold W default, the opcode constants OP_AND...OP_ROL (0000-1001), OP_MAX_VALID, and the state enum.
REQ-028 The register file SHALL be a sub-module, logic_regfile (2 async read ports, 2 prioritized write ports).

Verification
REQ-029 Load r1=0111, r2=0010; cmd op=0000 rd=3 rs1=1 rs2=2 -> res_valid 2 cycles after accept, res_data=0010, r3=0010.
REQ-030 Load r0=0111; cmd op=1000 rs1=0 imm_en=1 imm=1001 -> res_data=1011 (rotate right by 1), written to rd.
REQ-031 cmd op=1100 -> res_valid=1, res_err=1, res_data=0000, target register unchanged.
REQ-032 Hold cmd_valid high for 3 back-to-back commands -> cmd_ready pattern 1,0,0 repeating, exactly 3 res_valid pulses.
REQ-033 ld_en to rs1 (data 1010) on the accept edge with op=0111 -> res_data=0101; ld_en to rd on the WB edge -> the WB value persists.
REQ-034 Drop rst_n during EXEC -> no res_valid, all registers=0, cmd_ready=1 one cycle after release.

Source files
------------

// File: rtl/logic_pkg.sv
// Shared definitions for the logic-unit issue block.
// Holds the default datapath width, the logic-unit opcode map, the
// sequencer state type and an opcode validity helper.
package logic_pkg;

  localparam int unsigned W_DEF = 4;
  localparam int unsigned OP_W  = 4;

  // Logic-unit select codes; anything above OP_MAX_VALID is illegal
  localparam logic [OP_W-1:0] OP_AND  = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR   = 4'b0001;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b0010;
  localparam logic [OP_W-1:0] OP_NAND = 4'b0011;
  localparam logic [OP_W-1:0] OP_NOR  = 4'b0100;
  localparam logic [OP_W-1:0] OP_XNOR = 4'b0101;
  localparam logic [OP_W-1:0] OP_PASS = 4'b0110;
  localparam logic [OP_W-1:0] OP_NOT  = 4'b0111;
  localparam logic [OP_W-1:0] OP_ROR  = 4'b1000;
  localparam logic [OP_W-1:0] OP_ROL  = 4'b1001;

  localparam logic [OP_W-1:0] OP_MAX_VALID = OP_ROL;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  function automatic logic op_is_valid(input logic [OP_W-1:0] op);
    return (op <= OP_MAX_VALID);
  endfunction

endpackage

// File: rtl/logic_regfile.sv
// Register file for the logic-unit issue block.
// Ports:
//   clk, rst_n            - clock, async active-low reset (clears all entries)
//   rd_a_addr/rd_a_data   - async read port A
//   rd_b_addr/rd_b_data   - async read port B
//   wr_hi_en/addr/data    - high-priority write port (wins on address collision)
//   wr_lo_en/addr/data    - low-priority write port
module logic_regfile
  import logic_pkg::*;
#(
  parameter int unsigned W    = W_DEF,
  parameter int unsigned NREG = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [$clog2(NREG)-1:0] rd_a_addr,
  output logic [W-1:0]            rd_a_data,
  input  logic [$clog2(NREG)-1:0] rd_b_addr,
  output logic [W-1:0]            rd_b_data,
  input  logic                    wr_hi_en,
  input  logic [$clog2(NREG)-1:0] wr_hi_addr,
  input  logic [W-1:0]            wr_hi_data,
  input  logic                    wr_lo_en,
  input  logic [$clog2(NREG)-1:0] wr_lo_addr,
  input  logic [W-1:0]            wr_lo_data
);

  logic [W-1:0] regs [NREG];

  // Storage; the high-priority write is applied last so it overrides
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wr_lo_en) regs[wr_lo_addr] <= wr_lo_data;
      if (wr_hi_en) regs[wr_hi_addr] <= wr_hi_data;
    end
  end

  assign rd_a_data = regs[rd_a_addr];
  assign rd_b_data = regs[rd_b_addr];

endmodule

// File: rtl/logic_issue.sv
// Issue/writeback sequencer for an external combinational logic unit.
// Accepts one command at a time, reads operands from a local register file
// (with load-port bypass), drives the logic unit for one cycle, registers
// its result and writes it back while reporting it on the result port.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   cmd_valid/cmd_ready        - command handshake (ready only when idle)
//   cmd_op/rd/rs1/rs2          - opcode, destination and source registers
//   cmd_imm_en/cmd_imm         - immediate replaces reg[rs2] as operand 2
//   ld_en/ld_addr/ld_data      - direct register-file write port
//   alu_in1/alu_in2/alu_sel    - operands and select to the logic unit
//   alu_out                    - combinational result from the logic unit
//   res_valid/err/data/rd      - one-cycle result report
module logic_issue
  import logic_pkg::*;
#(
  parameter int unsigned W    = W_DEF,
  parameter int unsigned NREG = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [OP_W-1:0]         cmd_op,
  input  logic [$clog2(NREG)-1:0] cmd_rd,
  input  logic [$clog2(NREG)-1:0] cmd_rs1,
  input  logic [$clog2(NREG)-1:0] cmd_rs2,
  input  logic                    cmd_imm_en,
  input  logic [W-1:0]            cmd_imm,
  input  logic                    ld_en,
  input  logic [$clog2(NREG)-1:0] ld_addr,
  input  logic [W-1:0]            ld_data,
  output logic [W-1:0]            alu_in1,
  output logic [W-1:0]            alu_in2,
  output logic [OP_W-1:0]         alu_sel,
  input  logic [W-1:0]            alu_out,
  output logic                    res_valid,
  output logic                    res_err,
  output logic [W-1:0]            res_data,
  output logic [$clog2(NREG)-1:0] res_rd
);

  localparam int unsigned AW = $clog2(NREG);

  state_t          state;
  state_t          next_state;
  logic            accept;
  logic [W-1:0]    rs1_data;
  logic [W-1:0]    rs2_data;
  logic [W-1:0]    op1;
  logic [W-1:0]    op2;
  logic [AW-1:0]   rd_q;
  logic            wb_en;

  logic_regfile #(
    .W    (W),
    .NREG (NREG)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_a_addr  (cmd_rs1),
    .rd_a_data  (rs1_data),
    .rd_b_addr  (cmd_rs2),
    .rd_b_data  (rs2_data),
    .wr_hi_en   (wb_en),
    .wr_hi_addr (res_rd),
    .wr_hi_data (res_data),
    .wr_lo_en   (ld_en),
    .wr_lo_addr (ld_addr),
    .wr_lo_data (ld_data)
  );

  // Operand selection; a same-edge load to a source register is forwarded
  always_comb begin
    op1 = rs1_data;
    op2 = rs2_data;
    if (ld_en && (ld_addr == cmd_rs1)) op1 = ld_data;
    if (ld_en && (ld_addr == cmd_rs2)) op2 = ld_data;
    if (cmd_imm_en)                    op2 = cmd_imm;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept     = 1'b1;
          next_state = EXEC;
        end
      end
      EXEC:    next_state = WB;
      WB:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register; handshake outputs are registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      state     <= next_state;
      cmd_ready <= (next_state == IDLE);
      res_valid <= (next_state == WB);
    end
  end

  // Command capture; logic-unit inputs hold until the next acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_in1 <= '0;
      alu_in2 <= '0;
      alu_sel <= '0;
      rd_q    <= '0;
    end else if (accept) begin
      alu_in1 <= op1;
      alu_in2 <= op2;
      alu_sel <= cmd_op;
      rd_q    <= cmd_rd;
    end
  end

  // Result capture when leaving EXEC; illegal opcodes report zero data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data <= '0;
      res_err  <= 1'b0;
      res_rd   <= '0;
    end else if (state == EXEC) begin
      res_data <= op_is_valid(alu_sel) ? alu_out : '0;
      res_err  <= !op_is_valid(alu_sel);
      res_rd   <= rd_q;
    end
  end

  // Writeback happens on the edge leaving WB, only for legal opcodes
  assign wb_en = (state == WB) && !res_err;

endmodule
